// File: rtl/mac_rr_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mac_rr_job_scheduler
//  Purpose  : Time-shares one external MAC accumulator among NREQ requester
//             channels, one dot-product job at a time. Channels are granted
//             round-robin and keep the grant until the beat flagged req_last.
//             Each job clears the MAC, streams operand pairs through it, waits
//             for the MAC pipeline to drain, then returns the sum tagged with
//             the owning channel id and the (saturating) beat count.
//  Ports    : clk, reset               clock, synchronous active-high reset
//             req_valid/last/a/b       per-channel beat inputs (ch0 at LSBs)
//             req_ready                per-channel beat accept
//             resp_valid/ready         result handshake
//             resp_id/data/len         result channel, sum, beat count
//             mac_clear/a/b/valid_in   drive to the MAC instance
//             mac_f/mac_valid_out      return from the MAC instance
//             busy                     controller not idle
//  Revision : 1.0  initial release
// ============================================================================
module mac_rr_job_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 10,
    parameter int RW   = 20,
    parameter int CW   = 8,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IW-1:0]      resp_id,
    output logic [RW-1:0]      resp_data,
    output logic [CW-1:0]      resp_len,
    output logic               mac_clear,
    output logic [DW-1:0]      mac_a,
    output logic [DW-1:0]      mac_b,
    output logic               mac_valid_in,
    input  logic [RW-1:0]      mac_f,
    input  logic               mac_valid_out,
    output logic               busy
);

    // Up to three beats can be in flight in the 2-stage MAC plus the issue cycle.
    localparam int C_OUT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IW-1:0]      r_gnt;
    logic [IW-1:0]      r_rr_ptr;
    logic [CW-1:0]      r_beats;
    logic [C_OUT_W-1:0] r_out;
    logic               r_resp_valid;
    logic [IW-1:0]      r_resp_id;
    logic [RW-1:0]      r_resp_data;
    logic [CW-1:0]      r_resp_len;

    logic               w_pick_any;
    logic [IW-1:0]      w_pick_idx;
    logic               w_clear_state;
    logic               w_beat;
    logic               w_dec;
    logic               w_capture;

    // Round-robin search starting at r_rr_ptr, wrapping modulo NREQ.
    always_comb begin
        w_pick_any = 1'b0;
        w_pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_pick_any && req_valid[IW'((int'(r_rr_ptr) + i) % NREQ)]) begin
                w_pick_any = 1'b1;
                w_pick_idx = IW'((int'(r_rr_ptr) + i) % NREQ);
            end
        end
    end

    // Operands follow the granted channel combinationally; only mac_valid_in
    // qualifies them, so they need no gating outside STREAM.
    assign mac_a = req_a[r_gnt*DW +: DW];
    assign mac_b = req_b[r_gnt*DW +: DW];

    // A beat is issued exactly when the granted channel's beat is accepted.
    assign w_beat = (r_state == S_STREAM) && req_valid[r_gnt];

    // Stale MAC valids (pipe has no reset) are dropped once nothing is in flight.
    assign w_dec = mac_valid_out && (r_out != '0);

    // The final sum is the result that retires the last in-flight beat. The
    // last-beat STREAM cycle always issues a beat itself, so the count cannot
    // fall to zero there; capture can only happen in DRAIN.
    assign w_capture = (r_state == S_DRAIN) && mac_valid_out &&
                       (r_out == C_OUT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        req_ready     = '0;
        mac_valid_in  = 1'b0;
        w_clear_state = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_any) w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_clear_state = 1'b1;
                w_state_next  = S_STREAM;
            end
            S_STREAM: begin
                req_ready[r_gnt] = 1'b1;
                mac_valid_in     = req_valid[r_gnt];
                if (req_valid[r_gnt] && req_last[r_gnt]) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_capture) w_state_next = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign mac_clear = reset | w_clear_state;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt        <= '0;
            r_rr_ptr     <= '0;
            r_beats      <= '0;
            r_out        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_resp_len   <= '0;
        end else begin
            if (w_beat && !w_dec)      r_out <= r_out + 1'b1;
            else if (!w_beat && w_dec) r_out <= r_out - 1'b1;

            if ((r_state == S_IDLE) && w_pick_any) begin
                r_gnt    <= w_pick_idx;
                r_rr_ptr <= (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
            end

            if (r_state == S_CLEAR)
                r_beats <= '0;
            else if (w_beat && (r_beats != {CW{1'b1}}))
                r_beats <= r_beats + 1'b1;

            if (w_capture) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_gnt;
                r_resp_data  <= mac_f;
                r_resp_len   <= r_beats;
            end else if ((r_state == S_RESP) && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_len   = r_resp_len;

endmodule
`default_nettype wire

// File: tb/tb_mac_rr_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_rr_job_scheduler
//  Purpose  : Self-checking bench for mac_rr_job_scheduler. Contains a
//             behavioural 2-stage MAC, per-channel beat queues and a job-level
//             reference (arbitration order, wrapped dot product, saturating
//             length) computed from the scheduling rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_rr_job_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 10;
    localparam int RW   = 20;
    localparam int CW   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               resp_valid;
    logic               resp_ready;
    logic [1:0]         resp_id;
    logic [RW-1:0]      resp_data;
    logic [CW-1:0]      resp_len;
    logic               mac_clear;
    logic [DW-1:0]      mac_a;
    logic [DW-1:0]      mac_b;
    logic               mac_valid_in;
    logic [RW-1:0]      mac_f;
    logic               mac_valid_out;
    logic               busy;

    always #5 clk = ~clk;

    mac_rr_job_scheduler #(.NREQ(NREQ), .DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_len(resp_len),
        .mac_clear(mac_clear), .mac_a(mac_a), .mac_b(mac_b),
        .mac_valid_in(mac_valid_in), .mac_f(mac_f), .mac_valid_out(mac_valid_out),
        .busy(busy)
    );

    // Behavioural MAC: product stage, accumulate stage; clear is its sync reset,
    // the valid pipe is not reset.
    logic signed [RW-1:0] m_prod = '0;
    logic signed [RW-1:0] m_acc  = '0;
    logic                 m_v1   = 1'b0;
    logic                 m_v2   = 1'b0;
    always @(posedge clk) begin
        if (mac_clear) begin
            m_prod <= '0;
            m_acc  <= '0;
        end else begin
            m_prod <= $signed(mac_a) * $signed(mac_b);
            if (m_v1) m_acc <= m_acc + m_prod;
        end
        m_v1 <= mac_valid_in;
        m_v2 <= m_v1;
    end
    assign mac_f         = m_acc;
    assign mac_valid_out = m_v2;

    // ---------------- reference state ----------------
    typedef struct packed {
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        logic                 last;
    } beat_t;
    typedef struct packed {
        logic [RW-1:0] data;
        logic [CW-1:0] len;
    } res_t;

    beat_t  chq   [NREQ][$];
    res_t   chres [NREQ][$];
    longint job_sum [NREQ];
    int     job_len [NREQ];
    int     bub     [NREQ];
    int     id_log  [$];

    bit     model_idle;
    int     m_rr, m_gnt;
    res_t   exp_res;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc, n_acc, resp_hi, resp_cnt, resp_delay, bub_lo, bub_hi;
    int     first_ready, first_resp;
    logic [31:0] clear_hist;
    logic [1:0]    last_id;
    logic [RW-1:0] last_data;
    logic [CW-1:0] last_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one beat; on the last beat the job's expected result is fixed.
    task automatic add_beat(input int c, input logic signed [DW-1:0] a,
                            input logic signed [DW-1:0] b, input logic last);
        beat_t  bt;
        res_t   r;
        longint s;
        bt.a = a; bt.b = b; bt.last = last;
        chq[c].push_back(bt);
        job_sum[c] += longint'(a) * longint'(b);
        job_len[c]++;
        if (last) begin
            s      = job_sum[c];
            r.data = s[RW-1:0];
            r.len  = (job_len[c] >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(job_len[c]);
            chres[c].push_back(r);
            job_sum[c] = 0;
            job_len[c] = 0;
        end
    endtask

    task automatic add_random_job(input int c, input int n);
        for (int i = 0; i < n; i++)
            add_beat(c, DW'($urandom), DW'($urandom), 1'(i == n - 1));
    endtask

    function automatic int pending();
        int p;
        p = model_idle ? 0 : 1;
        for (int c = 0; c < NREQ; c++) p += chq[c].size();
        return p;
    endfunction

    // One clock: drive at edge+1, observe/check at negedge, update at edge+1.
    task automatic cycle();
        logic [NREQ-1:0] dv, acc;
        logic            hs, arb;
        int              g;
        beat_t           hb;
        dv = '0;
        for (int c = 0; c < NREQ; c++) begin
            req_a[c*DW +: DW] = '0;
            req_b[c*DW +: DW] = '0;
            req_last[c]       = 1'b0;
            if (chq[c].size() > 0 && bub[c] == 0) begin
                hb    = chq[c][0];
                dv[c] = 1'b1;
                req_a[c*DW +: DW] = hb.a;
                req_b[c*DW +: DW] = hb.b;
                req_last[c]       = hb.last;
            end
        end
        req_valid  = dv;
        resp_ready = resp_valid && (resp_cnt >= resp_delay);
        if (resp_valid) resp_cnt++;

        @(negedge clk);
        if (cyc < 32) clear_hist[cyc] = mac_clear;
        if (first_ready < 0 && (|req_ready)) first_ready = cyc;
        if (first_resp < 0 && resp_valid) first_resp = cyc;

        check("busy", 32'(busy), 32'(!model_idle));
        if (model_idle) begin
            check("idle_req_ready", 32'(req_ready), 32'd0);
            check("idle_resp_valid", 32'(resp_valid), 32'd0);
        end else begin
            check("ungranted_ready", 32'(req_ready & ~(NREQ'(1) << m_gnt)), 32'd0);
            if (resp_valid) begin
                resp_hi++;
                check("resp_id", 32'(resp_id), 32'(m_gnt));
                check("resp_data", 32'(resp_data), 32'(exp_res.data));
                check("resp_len", 32'(resp_len), 32'(exp_res.len));
            end
        end

        acc = dv & req_ready;
        hs  = resp_valid & resp_ready;
        arb = model_idle && (|dv);
        g   = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_rr + k) % NREQ;
            if (g < 0 && dv[idx]) g = idx;
        end
        if (hs) begin
            last_id   = resp_id;
            last_data = resp_data;
            last_len  = resp_len;
            id_log.push_back(int'(resp_id));
        end

        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NREQ; c++) if (bub[c] > 0) bub[c]--;
        for (int c = 0; c < NREQ; c++) begin
            if (acc[c]) begin
                hb = chq[c].pop_front();
                n_acc++;
                if (!hb.last) bub[c] = $urandom_range(bub_hi, bub_lo);
            end
        end
        if (hs) begin
            model_idle = 1'b1;
            resp_cnt   = 0;
        end
        if (arb) begin
            model_idle = 1'b0;
            m_gnt      = g;
            m_rr       = (g + 1) % NREQ;
            if (chres[g].size() > 0) exp_res = chres[g].pop_front();
        end
    endtask

    task automatic run_jobs(input int budget);
        int k;
        k = 0;
        while (pending() != 0 && k < budget) begin
            cycle();
            k++;
        end
        check("job_budget", 32'(pending()), 32'd0);
    endtask

    // Synchronous reset for n edges; any queued or running work is abandoned.
    task automatic do_reset(input int n);
        reset      = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        resp_ready = 1'b0;
        for (int c = 0; c < NREQ; c++) begin
            chq[c].delete();
            chres[c].delete();
            bub[c] = 0; job_sum[c] = 0; job_len[c] = 0;
        end
        model_idle = 1'b1;
        m_rr       = 0;
        resp_cnt   = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_mac_clear", 32'(mac_clear), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_mac_valid_in", 32'(mac_valid_in), 32'd0);
            check("rst_resp_data", 32'(resp_data), 32'd0);
            check("rst_resp_len_id", 32'({resp_len, resp_id}), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_last = '0; req_a = '0; req_b = '0;
        resp_ready = 1'b0;
        bub_lo = 0; bub_hi = 0; resp_delay = 0; n_acc = 0; resp_hi = 0;
        cyc = 0; first_ready = -1; first_resp = -1; clear_hist = '0;
        m_gnt = 0; exp_res = '0;
        do_reset(3);

        // T1: single beat, latency landmarks.
        cyc = 0; first_ready = -1; first_resp = -1; clear_hist = '0;
        add_beat(0, 10'sd3, 10'sd4, 1'b1);
        run_jobs(50);
        check("t1_first_ready_cycle", 32'(first_ready), 32'd2);
        check("t1_resp_cycle", 32'(first_resp), 32'd5);
        check("t1_clear_cycles", clear_hist, 32'h0000_0002);
        check("t1_data", 32'(last_data), 32'd12);
        check("t1_id_len", 32'({last_id, last_len}), 32'({2'd0, 8'd1}));

        // T2: three beats on ch1, negative result.
        add_beat(1, 10'sd2, 10'sd3, 1'b0);
        add_beat(1, -10'sd4, 10'sd5, 1'b0);
        add_beat(1, 10'sd7, -10'sd1, 1'b1);
        run_jobs(50);
        check("t2_data", 32'(last_data), 32'h000F_FFEB);
        check("t2_id_len", 32'({last_id, last_len}), 32'({2'd1, 8'd3}));

        // T3: arbitration order from rr_ptr=0, then all four requesting.
        do_reset(2);
        id_log.delete();
        add_beat(0, 10'sd1, 10'sd1, 1'b1);
        add_beat(2, 10'sd2, 10'sd2, 1'b1);
        run_jobs(100);
        for (int c = 0; c < NREQ; c++) add_beat(c, DW'(c + 5), 10'sd3, 1'b1);
        run_jobs(200);
        check("t3_log_size", 32'(id_log.size()), 32'd6);
        if (id_log.size() == 6) begin
            check("t3_order0", 32'(id_log[0]), 32'd0);
            check("t3_order1", 32'(id_log[1]), 32'd2);
            check("t3_order2", 32'(id_log[2]), 32'd3);
            check("t3_order3", 32'(id_log[3]), 32'd0);
            check("t3_order4", 32'(id_log[4]), 32'd1);
            check("t3_order5", 32'(id_log[5]), 32'd2);
        end

        // T4: bubbles between beats and a back-pressured response.
        bub_lo = 2; bub_hi = 2; resp_delay = 5; resp_hi = 0;
        add_beat(3, 10'sd5, 10'sd6, 1'b0);
        add_beat(3, -10'sd3, 10'sd7, 1'b0);
        add_beat(3, 10'sd9, 10'sd9, 1'b0);
        add_beat(3, -10'sd10, -10'sd2, 1'b1);
        run_jobs(200);
        check("t4_resp_hold_cycles", 32'(resp_hi), 32'd6);
        check("t4_data", 32'(last_data), 32'd110);
        check("t4_id_len", 32'({last_id, last_len}), 32'({2'd3, 8'd4}));
        bub_lo = 0; bub_hi = 0; resp_delay = 0;

        // T5: wraparound and length saturation.
        add_beat(2, 10'sh200, 10'sh200, 1'b0);
        add_beat(2, 10'sh200, 10'sh200, 1'b1);
        run_jobs(50);
        check("t5_wrap_data", 32'(last_data), 32'h0008_0000);
        add_random_job(0, 300);
        run_jobs(800);
        check("t5_sat_len", 32'(last_len), 32'd255);

        // T6: reset in the middle of a 4-beat job.
        n_acc = 0;
        for (int c = 0; c < 4; c++) add_beat(2, 10'sd1, 10'sd1, 1'(c == 3));
        for (int k = 0; k < 30 && n_acc < 2; k++) cycle();
        check("t6_beats_before_reset", 32'(n_acc), 32'd2);
        do_reset(2);
        repeat (6) cycle();
        add_beat(1, 10'sd6, 10'sd7, 1'b1);
        run_jobs(50);
        check("t6_next_data", 32'(last_data), 32'd42);
        check("t6_next_id_len", 32'({last_id, last_len}), 32'({2'd1, 8'd1}));

        // Randomized batches against the reference.
        bub_hi = 2;
        for (int batch = 0; batch < 8; batch++) begin
            for (int c = 0; c < NREQ; c++) begin
                int nj;
                nj = $urandom_range(2, 0);
                for (int j = 0; j < nj; j++) add_random_job(c, $urandom_range(8, 1));
            end
            resp_delay = $urandom_range(3, 0);
            run_jobs(3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
